// File: rtl/uart_echo_ctrl_if.sv
// FIFO-side bundle of the UART echo controller: rx/tx FIFO flags in, pop/push strobes out.
// The controller owns the master modport and the FIFO pair owns the slave modport.

interface uart_echo_ctrl_if #(
  parameter int DATA_BITS = 8
);
  // Handshake: read_data is first-word-fall-through and valid whenever rx_empty=0;
  // read_uart is a one-cycle pop of that word. write_uart is a one-cycle push of
  // write_data and is only raised when tx_full was low on the preceding edge.
  logic                 rx_empty;
  logic                 rx_full;
  logic                 tx_full;
  logic [DATA_BITS-1:0] read_data;
  logic                 read_uart;
  logic                 write_uart;
  logic [DATA_BITS-1:0] write_data;

  modport master (
    input  rx_empty,
    input  rx_full,
    input  tx_full,
    input  read_data,
    output read_uart,
    output write_uart,
    output write_data
  );

  modport slave (
    output rx_empty,
    output rx_full,
    output tx_full,
    output read_data,
    input  read_uart,
    input  write_uart,
    input  write_data
  );
endinterface

// File: rtl/uart_echo_ctrl.sv
// Echo controller: pops bytes from the UART rx FIFO and pushes them (optionally
// case-inverted) into the tx FIFO, with statistics, sticky error flags and a tx-full timeout.

module uart_echo_ctrl #(
  parameter int DATA_BITS   = 8,
  parameter int CNT_BITS    = 16,
  parameter int TX_WAIT_MAX = 1023
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           mode,
  input  logic                 btn_tick,
  input  logic                 clr_stats,
  uart_echo_ctrl_if.master     fifo,
  output logic [DATA_BITS-1:0] last_byte,
  output logic [CNT_BITS-1:0]  byte_count,
  output logic                 overrun_flag,
  output logic                 tx_drop_flag,
  output logic                 busy,
  output logic                 o_dbg_state
);

  localparam int WAIT_BITS = (TX_WAIT_MAX < 2) ? 1 : $clog2(TX_WAIT_MAX + 1);
  localparam logic [WAIT_BITS-1:0] WAIT_LAST = WAIT_BITS'(TX_WAIT_MAX - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t               r_state;
  logic [DATA_BITS-1:0] r_hold;
  logic                 r_xform;
  logic [WAIT_BITS-1:0] r_wait;
  logic                 r_rd;
  logic                 r_wr;
  logic [DATA_BITS-1:0] r_wd;
  logic [DATA_BITS-1:0] r_last;
  logic [CNT_BITS-1:0]  r_count;
  logic                 r_overrun;
  logic                 r_drop_flag;
  logic                 r_busy;

  logic                 w_trigger;
  logic                 w_push;
  logic                 w_drop;
  logic [DATA_BITS-1:0] w_xdata;
  logic [CNT_BITS-1:0]  w_count_base;
  logic [CNT_BITS-1:0]  w_count_next;

  // ASCII case inversion; only meaningful for 8-bit words, identity otherwise.
  function automatic logic [DATA_BITS-1:0] f_xform(input logic [DATA_BITS-1:0] d,
                                                   input logic              en);
    logic [DATA_BITS-1:0] res;
    res = d;
    if (en && (DATA_BITS == 8)) begin
      if ((d >= DATA_BITS'(8'h41)) && (d <= DATA_BITS'(8'h5A)))
        res = d + DATA_BITS'(8'h20);
      else if ((d >= DATA_BITS'(8'h61)) && (d <= DATA_BITS'(8'h7A)))
        res = d - DATA_BITS'(8'h20);
    end
    return res;
  endfunction

  assign w_trigger = (r_state == S_IDLE) && !fifo.rx_empty &&
                     ((mode == 2'b01) || (mode == 2'b10) || ((mode == 2'b00) && btn_tick));
  assign w_push    = (r_state == S_SEND) && !fifo.tx_full;
  assign w_drop    = (r_state == S_SEND) && fifo.tx_full && (r_wait == WAIT_LAST);
  assign w_xdata   = f_xform(r_hold, r_xform);

  // A clear and a push in the same cycle leave the counter at one.
  assign w_count_base = clr_stats ? '0 : r_count;
  assign w_count_next = (w_push && (w_count_base != '1)) ? (w_count_base + CNT_BITS'(1))
                                                         : w_count_base;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_hold      <= '0;
      r_xform     <= 1'b0;
      r_wait      <= '0;
      r_rd        <= 1'b0;
      r_wr        <= 1'b0;
      r_wd        <= '0;
      r_last      <= '0;
      r_count     <= '0;
      r_overrun   <= 1'b0;
      r_drop_flag <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_rd <= 1'b0;
      r_wr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_trigger) begin
            r_hold  <= fifo.read_data;
            r_last  <= fifo.read_data;
            r_xform <= (mode == 2'b10);
            r_wait  <= '0;
            r_rd    <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_SEND;
          end
        end
        S_SEND: begin
          if (!fifo.tx_full) begin
            r_wr    <= 1'b1;
            r_wd    <= w_xdata;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_drop) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_wait <= r_wait + WAIT_BITS'(1);
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
      // Sticky flags: a same-cycle set overrides the clear.
      r_overrun   <= (r_overrun & ~clr_stats) | fifo.rx_full;
      r_drop_flag <= (r_drop_flag & ~clr_stats) | w_drop;
      r_count     <= w_count_next;
    end
  end

  assign fifo.read_uart  = r_rd;
  assign fifo.write_uart = r_wr;
  assign fifo.write_data = r_wd;
  assign last_byte       = r_last;
  assign byte_count      = r_count;
  assign overrun_flag    = r_overrun;
  assign tx_drop_flag    = r_drop_flag;
  assign busy            = r_busy;
  assign o_dbg_state     = r_state;

endmodule
